spi_flash_arb: RTL
==================

Name: spi_flash_arb

Overview:
- Arbitrates the single external SPI flash pin set between the streaming reader (spi_stream) and a second "direct" SPI master (boot loader / firmware-driven command engine).
- The stream engine owns the pins by default.
- The direct master gets the pins only after the stream engine has been paused via its pause_req/pause_ack handshake, and after a guaranteed chip-select-high gap.
- Sits between both masters and the SPI pads. Its strm_pause_req is ORed with the register-driven pause request at integration.

Parameters:
- GAP_CYCLES, 4: clk cycles of forced idle pads (cs_n=1, sck=0, mosi=0) on every ownership change. Legal range 1..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- strm_cs_n  input  1  stream engine chip select
- strm_sck  input  1  stream engine SCK
- strm_mosi  input  1  stream engine MOSI
- strm_miso  output  1  MISO returned to stream engine
- strm_pause_req  output  1  request stream engine to pause
- strm_pause_ack  input  1  stream engine paused (idle or mid-transfer, cs_n high)
- dir_req  input  1  direct master requests pins; level, held for whole ownership
- dir_gnt  output  1  direct master owns pins
- dir_cs_n  input  1  direct master chip select
- dir_sck  input  1  direct master SCK
- dir_mosi  input  1  direct master MOSI
- dir_miso  output  1  MISO returned to direct master
- spi_cs_n  output  1  pad chip select
- spi_sck  output  1  pad SCK
- spi_mosi  output  1  pad MOSI
- spi_miso  input  1  pad MISO
- owner_dir  output  1  status: pad mux currently selects the direct master

Behaviour:
- States: S_STREAM, S_PAUSE_WAIT, S_GAP_TO_DIR, S_DIR, S_GAP_TO_STREAM.
- Reset: state S_STREAM, gap counter 0. strm_pause_req=0, dir_gnt=0, owner_dir=0.
- Control outputs are registered and decoded from state only:
  - strm_pause_req=1 in every state except S_STREAM.
  - dir_gnt=1 and owner_dir=1 only in S_DIR.
- Pad mux:
  - S_STREAM: pads = strm_*.
  - S_DIR: pads = dir_*.
  - S_PAUSE_WAIT: pads = strm_*, so the stream engine can finish its current word and raise its own cs_n.
  - Gap states: pads forced to cs_n=1, sck=0, mosi=0.
  - The select changes only on entry/exit of a gap state, so the combinational mux never glitches an active bus.
- MISO: spi_miso routes to strm_miso when not owner_dir, else to dir_miso. The non-selected return is held 0.
- S_STREAM: if dir_req, go to S_PAUSE_WAIT.
- S_PAUSE_WAIT:
  - If !dir_req, return to S_STREAM (request withdrawn).
  - Else if strm_pause_ack && strm_cs_n, go to S_GAP_TO_DIR and load counter = GAP_CYCLES-1.
- S_GAP_TO_DIR:
  - If !dir_req, go to S_GAP_TO_STREAM and reload counter = GAP_CYCLES-1.
  - Else if counter==0, go to S_DIR.
  - Else decrement the counter.
- S_DIR: when dir_req deasserts, go to S_GAP_TO_STREAM and load counter = GAP_CYCLES-1. dir_gnt falls the same edge. The direct master must have raised dir_cs_n before dropping dir_req; the arbiter forces pad cs_n high regardless.
- S_GAP_TO_STREAM:
  - When counter==0, go to S_STREAM; strm_pause_req falls that edge.
  - dir_req during this state is ignored until S_STREAM has been occupied for at least 1 cycle, guaranteeing the stream engine sees pause_req low.
- Latency:
  - dir_req rising to dir_gnt rising = (cycles in S_PAUSE_WAIT) + GAP_CYCLES + 1.
  - dir_req falling to strm_pause_req falling = GAP_CYCLES + 1.
- strm_pause_ack dropping while in S_DIR or the gap states is a protocol violation. The stream-side pads stay disconnected; no recovery is required.
- Reset mid-ownership returns pads to the stream engine immediately (asynchronous). Both masters are reset by the same rst_n.

Test Plan:
- GAP_CYCLES=4, strm_pause_ack tied 1, strm_cs_n=1. Raise dir_req at cycle 0 -> strm_pause_req=1 at cycle 1, dir_gnt=1 at cycle 6. Pads read cs_n=1/sck=0/mosi=0 during cycles 2-5.
- Stream mid-word (strm_cs_n=0, toggling sck), dir_req raised -> pads keep following strm_*. Ack arrives 40 cycles later with cs_n=1 -> dir_gnt rises 5 cycles after the ack. No truncated SCK pulse appears on the pads.
- In S_DIR, drive dir_sck/dir_mosi toggling and spi_miso=1 -> pads follow dir_*, dir_miso=1, strm_miso=0. Drop dir_req -> dir_gnt=0 next edge, strm_pause_req=0 after 5 cycles, pads then follow strm_*.
- Withdraw dir_req in S_PAUSE_WAIT -> returns to S_STREAM, pause_req=0, dir_gnt never asserted. Withdraw during S_GAP_TO_DIR at counter=2 -> full 4-cycle gap to stream, then S_STREAM.
- dir_req re-raised during S_GAP_TO_STREAM -> pause_req is low for at least 1 cycle before it is reasserted.
- Assert rst_n low while in S_DIR -> dir_gnt=0, strm_pause_req=0, owner_dir=0 immediately; pads follow strm_*.

Source files
------------

// File: rtl/spi_flash_arb.sv
// spi_flash_arb: shares one SPI flash pin set between the streaming reader
// (strm_*) and a direct SPI master (dir_*). The stream engine owns the pads by
// default. The direct master is granted only after the stream engine has
// acknowledged a pause with its cs_n high. Every ownership change passes
// through GAP_CYCLES clocks of idle pads (cs_n=1, sck=0, mosi=0).
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   strm_cs_n/sck/mosi, strm_miso  stream engine SPI signals
//   strm_pause_req, strm_pause_ack pause handshake with the stream engine
//   dir_req, dir_gnt               direct master request (level) / grant
//   dir_cs_n/sck/mosi, dir_miso    direct master SPI signals
//   spi_cs_n/sck/mosi, spi_miso    pad side
//   owner_dir                      status: pad mux selects the direct master
module spi_flash_arb #(
  parameter int unsigned GAP_CYCLES = 4  // legal range 1..255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strm_cs_n,
  input  logic strm_sck,
  input  logic strm_mosi,
  output logic strm_miso,
  output logic strm_pause_req,
  input  logic strm_pause_ack,
  input  logic dir_req,
  output logic dir_gnt,
  input  logic dir_cs_n,
  input  logic dir_sck,
  input  logic dir_mosi,
  output logic dir_miso,
  output logic spi_cs_n,
  output logic spi_sck,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic owner_dir
);

  localparam logic [7:0] GapLoad = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_STREAM,
    S_PAUSE_WAIT,
    S_GAP_TO_DIR,
    S_DIR,
    S_GAP_TO_STREAM
  } state_e;

  state_e     state_q;
  logic [7:0] cnt_q;

  // Control outputs are updated alongside the state so they always reflect
  // the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_STREAM;
      cnt_q          <= 8'd0;
      strm_pause_req <= 1'b0;
      dir_gnt        <= 1'b0;
      owner_dir      <= 1'b0;
    end else begin
      case (state_q)
        S_STREAM: begin
          if (dir_req) begin
            state_q        <= S_PAUSE_WAIT;
            strm_pause_req <= 1'b1;
          end
        end
        S_PAUSE_WAIT: begin
          if (!dir_req) begin
            state_q        <= S_STREAM;
            strm_pause_req <= 1'b0;
          end else if (strm_pause_ack && strm_cs_n) begin
            state_q <= S_GAP_TO_DIR;
            cnt_q   <= GapLoad;
          end
        end
        S_GAP_TO_DIR: begin
          if (!dir_req) begin
            // Pads were already idle; still give the stream a full gap.
            state_q <= S_GAP_TO_STREAM;
            cnt_q   <= GapLoad;
          end else if (cnt_q == 8'd0) begin
            state_q   <= S_DIR;
            dir_gnt   <= 1'b1;
            owner_dir <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_DIR: begin
          if (!dir_req) begin
            state_q   <= S_GAP_TO_STREAM;
            cnt_q     <= GapLoad;
            dir_gnt   <= 1'b0;
            owner_dir <= 1'b0;
          end
        end
        S_GAP_TO_STREAM: begin
          // dir_req is deliberately ignored here: S_STREAM is always held for
          // at least one cycle so the stream engine sees pause_req low.
          if (cnt_q == 8'd0) begin
            state_q        <= S_STREAM;
            strm_pause_req <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q        <= S_STREAM;
          cnt_q          <= 8'd0;
          strm_pause_req <= 1'b0;
          dir_gnt        <= 1'b0;
          owner_dir      <= 1'b0;
        end
      endcase
    end
  end

  // Pad mux selected from the registered state only; the selection flips
  // only around gap states, so an active bus is never switched mid-transfer.
  always_comb begin
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    case (state_q)
      S_STREAM, S_PAUSE_WAIT: begin
        spi_cs_n = strm_cs_n;
        spi_sck  = strm_sck;
        spi_mosi = strm_mosi;
      end
      S_DIR: begin
        spi_cs_n = dir_cs_n;
        spi_sck  = dir_sck;
        spi_mosi = dir_mosi;
      end
      default: begin
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
      end
    endcase
  end

  assign strm_miso = owner_dir ? 1'b0 : spi_miso;
  assign dir_miso  = owner_dir ? spi_miso : 1'b0;

endmodule
